// File: rtl/boot_pkg.sv
// Shared definitions for the boot load sequencer: FSM states and the byte
// strides that turn a word index into an external-port byte address.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_I,
        ST_LOAD_D,
        ST_RUN,
        ST_DONE
    } boot_state_e;

    // Instruction words are 32 bits, data words are 64 bits.
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

endpackage

// File: rtl/load_counter.sv
// Loadable up-counter with a terminal-count flag (count equals limit).
module load_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    // Load takes priority over increment; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/boot_load_sequencer.sv
// Streams instruction then data words into two memories through their
// external ports, then enables the CPU for a fixed number of cycles.
import boot_pkg::*;

module boot_load_sequencer #(
    parameter int unsigned IMEM_ADDR_W = 9,
    parameter int unsigned DMEM_ADDR_W = 10,
    parameter int unsigned CYC_W       = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   imem_words,
    input  logic [DMEM_ADDR_W:0]   dmem_words,
    input  logic [CYC_W-1:0]       run_cycles,
    input  logic                   s_valid,
    input  logic [63:0]            s_data,
    output logic                   s_ready,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic                   ren_ext,
    output logic [31:0]            wdata_ext,
    output logic [63:0]            addr_ext_2,
    output logic                   wen_ext_2,
    output logic                   ren_ext_2,
    output logic [63:0]            wdata_ext_2,
    output logic                   cpu_enable,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned WW = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;
    localparam logic [WW-1:0] ONE_W = WW'(1);

    boot_state_e          state_q;
    logic [IMEM_ADDR_W:0] imem_cnt_q;
    logic [DMEM_ADDR_W:0] dmem_cnt_q;
    logic [CYC_W-1:0]     run_cnt_q;

    logic [63:0] addr_ext_q, addr_ext_2_q, wdata_ext_2_q;
    logic [31:0] wdata_ext_q;
    logic        wen_ext_q, wen_ext_2_q, ren_ext_q, ren_ext_2_q, cpu_en_q;

    logic [WW-1:0]    word_cnt, word_lim;
    logic             word_tc, word_load;
    logic [CYC_W-1:0] cyc_cnt;
    logic             cyc_tc, cyc_en;
    logic             start_acc, ready_d, beat;

    // Stream handshake and counter control derived from the current state.
    always_comb begin
        start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        ready_d   = 1'b0;
        word_lim  = '0;
        if (state_q == ST_LOAD_I) begin
            ready_d  = (word_cnt < WW'(imem_cnt_q));
            word_lim = WW'(imem_cnt_q) - ONE_W;
        end else if (state_q == ST_LOAD_D) begin
            ready_d  = (word_cnt < WW'(dmem_cnt_q));
            word_lim = WW'(dmem_cnt_q) - ONE_W;
        end
        beat      = s_valid && ready_d;
        word_load = start_acc || (beat && word_tc);
        cyc_en    = (state_q == ST_RUN) && (cyc_cnt < run_cnt_q);
    end

    load_counter #(.W(WW)) u_word_cnt (
        .clk        (clk),
        .rst_n      (arst_n),
        .load_i     (word_load),
        .load_val_i ('0),
        .en_i       (beat),
        .limit_i    (word_lim),
        .count_o    (word_cnt),
        .tc_o       (word_tc)
    );

    load_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk        (clk),
        .rst_n      (arst_n),
        .load_i     (start_acc),
        .load_val_i ('0),
        .en_i       (cyc_en),
        .limit_i    (run_cnt_q),
        .count_o    (cyc_cnt),
        .tc_o       (cyc_tc)
    );

    // Sequencer FSM with registered memory-port and enable outputs.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q       <= ST_IDLE;
            imem_cnt_q    <= '0;
            dmem_cnt_q    <= '0;
            run_cnt_q     <= '0;
            addr_ext_q    <= '0;
            wdata_ext_q   <= '0;
            wen_ext_q     <= 1'b0;
            ren_ext_q     <= 1'b0;
            addr_ext_2_q  <= '0;
            wdata_ext_2_q <= '0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            cpu_en_q      <= 1'b0;
        end else begin
            wen_ext_q   <= 1'b0;
            wen_ext_2_q <= 1'b0;
            ren_ext_q   <= 1'b0;
            ren_ext_2_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    cpu_en_q <= 1'b0;
                    if (start_acc) begin
                        imem_cnt_q <= imem_words;
                        dmem_cnt_q <= dmem_words;
                        run_cnt_q  <= run_cycles;
                        if (imem_words != '0)      state_q <= ST_LOAD_I;
                        else if (dmem_words != '0) state_q <= ST_LOAD_D;
                        else                       state_q <= ST_RUN;
                    end
                end
                ST_LOAD_I: begin
                    if (beat) begin
                        wen_ext_q   <= 1'b1;
                        addr_ext_q  <= 64'(word_cnt) * 64'(IMEM_STRIDE);
                        wdata_ext_q <= s_data[31:0];
                        if (word_tc) begin
                            state_q <= (dmem_cnt_q != '0) ? ST_LOAD_D : ST_RUN;
                        end
                    end
                end
                ST_LOAD_D: begin
                    if (beat) begin
                        wen_ext_2_q   <= 1'b1;
                        addr_ext_2_q  <= 64'(word_cnt) * 64'(DMEM_STRIDE);
                        wdata_ext_2_q <= s_data;
                        if (word_tc) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Enable lags RUN entry by one cycle; the counter counts enabled cycles.
                    if (cyc_tc) begin
                        cpu_en_q <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        cpu_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cpu_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = ready_d;
    assign addr_ext    = addr_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = ren_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign cpu_enable  = cpu_en_q;
    assign busy        = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D) || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Self-checking bench for boot_load_sequencer. The reference model is a
// timeline: beat k goes to imem (k < ni) or dmem, writes appear one edge
// after acceptance, RUN begins at the edge of the last beat, and the enable
// window and DONE follow by fixed offsets from that edge.
module tb_boot_load_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [9:0]  imem_words;
    logic [10:0] dmem_words;
    logic [31:0] run_cycles;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, done;

    int errors = 0;
    int checks = 0;

    boot_load_sequencer #(
        .IMEM_ADDR_W (9),
        .DMEM_ADDR_W (10),
        .CYC_W       (32)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_words  (imem_words),
        .dmem_words  (dmem_words),
        .run_cycles  (run_cycles),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_ready"},    64'(s_ready),    64'd0);
        chk({tag, ".wen_ext"},    64'(wen_ext),    64'd0);
        chk({tag, ".wen_ext_2"},  64'(wen_ext_2),  64'd0);
        chk({tag, ".ren_ext"},    64'(ren_ext),    64'd0);
        chk({tag, ".ren_ext_2"},  64'(ren_ext_2),  64'd0);
        chk({tag, ".cpu_enable"}, 64'(cpu_enable), 64'd0);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".done"},       64'(done),       64'd0);
        chk({tag, ".addr_ext"},   addr_ext,        64'd0);
        chk({tag, ".addr_ext_2"}, addr_ext_2,      64'd0);
    endtask

    // Compare every output after edge e against the timeline model.
    task automatic chk_edge(input string tag, input int e, input bit acc, input int idx,
                            input logic [63:0] d, input int ni, input int beats,
                            input int tot, input int t_run, input int rc);
        bit exp_wi, exp_wd, exp_busy, exp_en, exp_done;
        exp_wi   = acc && (idx < ni);
        exp_wd   = acc && (idx >= ni);
        exp_busy = (t_run < 0) || (e < t_run + rc + 1);
        exp_en   = (t_run >= 0) && (e >= t_run + 1) && (e <= t_run + rc);
        exp_done = (t_run >= 0) && (e >= t_run + rc + 1);
        chk({tag, ".wen_ext"},    64'(wen_ext),    64'(exp_wi));
        chk({tag, ".wen_ext_2"},  64'(wen_ext_2),  64'(exp_wd));
        chk({tag, ".ren_ext"},    64'(ren_ext),    64'd0);
        chk({tag, ".ren_ext_2"},  64'(ren_ext_2),  64'd0);
        chk({tag, ".busy"},       64'(busy),       64'(exp_busy));
        chk({tag, ".cpu_enable"}, 64'(cpu_enable), 64'(exp_en));
        chk({tag, ".done"},       64'(done),       64'(exp_done));
        chk({tag, ".s_ready"},    64'(s_ready),    64'(beats < tot));
        if (exp_wi) begin
            chk({tag, ".addr_ext"},  addr_ext,       64'(idx) * 64'd4);
            chk({tag, ".wdata_ext"}, 64'(wdata_ext), {32'd0, d[31:0]});
        end
        if (exp_wd) begin
            chk({tag, ".addr_ext_2"},  addr_ext_2,  64'(idx - ni) * 64'd8);
            chk({tag, ".wdata_ext_2"}, wdata_ext_2, d);
        end
    endtask

    // vmode: 0 continuous valid, 1 random valid, 2 pattern 1,0,0,1.
    // smode: start during busy cycles 0 never, 1 random, 2 always.
    // abort_e: edge index at which reset is asserted (-1 for none).
    task automatic run_seq(input string tag, input int ni, input int nd, input int rc,
                           input int vmode, input int smode, input bit dfix, input int abort_e);
        int beats = 0;
        int tot = ni + nd;
        int t_run = -1;
        int e = 0;
        int idx;
        bit acc, v;
        logic [63:0] d;
        imem_words = 10'(ni);
        dmem_words = 11'(nd);
        run_cycles = 32'(rc);
        start      = 1'b1;
        s_valid    = 1'($urandom_range(0, 1));
        s_data     = {$urandom, $urandom};
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b0;
        if (tot == 0) t_run = 0;
        chk_edge({tag, ".e0"}, 0, 1'b0, 0, '0, ni, beats, tot, t_run, rc);
        while ((t_run < 0) || (e < t_run + rc + 1)) begin
            e++;
            if (e > 2000) begin
                chk({tag, ".timeout"}, 64'(e), 64'd2000);
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (((e - 1) % 4) == 0) || (((e - 1) % 4) == 3);
            endcase
            d       = dfix ? 64'hAAAA_BBBB_1234_5678 : {$urandom, $urandom};
            s_valid = v;
            s_data  = d;
            start   = (smode == 2) ? 1'b1 : (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            arst_n  = (e == abort_e) ? 1'b0 : 1'b1;
            acc     = v && (beats < tot);
            idx     = beats;
            @(posedge clk); #1;
            start   = 1'b0;
            s_valid = 1'b0;
            if (e == abort_e) begin
                arst_n = 1'b1;
                chk_all_zero({tag, ".abort"});
                return;
            end
            if (acc) begin
                beats++;
                if (beats == tot) t_run = e;
            end
            chk_edge(tag, e, acc, idx, d, ni, beats, tot, t_run, rc);
        end
    endtask

    initial begin
        arst_n     = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        imem_words = '0;
        dmem_words = '0;
        run_cycles = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        arst_n = 1'b1;
        @(posedge clk); #1;

        run_seq("basic_3_2_5",   3, 2, 5, 0, 0, 1'b0, -1);
        run_seq("gap_1001",      2, 0, 1, 2, 0, 1'b0, -1);
        run_seq("all_zero",      0, 0, 0, 0, 0, 1'b0, -1);
        // RUN entered at edge 3; reset asserted on the second RUN cycle.
        run_seq("abort_run",     2, 1, 10, 0, 0, 1'b0, 5);
        run_seq("after_abort",   2, 2, 3, 0, 0, 1'b0, -1);
        run_seq("start_ignored", 2, 3, 4, 0, 2, 1'b0, -1);
        run_seq("restart_done",  1, 1, 2, 0, 0, 1'b0, -1);
        run_seq("hi_dropped",    4, 1, 2, 1, 0, 1'b1, -1);
        run_seq("dmem_only",     0, 3, 1, 1, 1, 1'b0, -1);
        run_seq("abort_load",    5, 5, 3, 1, 0, 1'b0, 4);
        run_seq("after_abort2",  1, 1, 1, 0, 0, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            run_seq($sformatf("rand%0d", i), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1, 1, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
